// File: rtl/css_mcu0_el2_ifu_fb_ctl_pkg.sv
// Shared types for the IFU fetch buffer: buffer entry layout, depth constant, RVC helper.
package css_mcu0_el2_pkg;

  localparam int FB_DEPTH_LOG2 = 2;

  typedef struct packed {
    logic [1:0]  hw_valid;
    logic [31:0] data;
    logic [31:2] pc;
    logic        icaf;
  } el2_fb_entry_t;

  // A halfword starts a compressed instruction unless its two low bits are both set.
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/css_mcu0_el2_ifu_fb_ctl_if.sv
// Fetch-return / decode handshake bundle seen by the fetch buffer.
interface css_mcu0_el2_ifu_fb_ctl_if;
  logic        ifc_fetch_req_f;
  logic        ic_hit_f;
  logic [31:1] ifc_fetch_addr_f;
  logic [31:0] ic_data_f;
  logic        ic_access_fault_f;
  logic        exu_flush_final;
  logic        dec_ib_ready;
  logic        ifu_i0_valid;
  logic [31:0] ifu_i0_instr;
  logic [31:1] ifu_i0_pc;
  logic        ifu_i0_pc4;
  logic        ifu_i0_icaf;
  logic        ifu_fb_consume1;
  logic        ifu_fb_consume2;
  logic        fb_overflow_err;

  modport master (
    output ifc_fetch_req_f, ic_hit_f, ifc_fetch_addr_f, ic_data_f, ic_access_fault_f,
           exu_flush_final, dec_ib_ready,
    input  ifu_i0_valid, ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_i0_icaf,
           ifu_fb_consume1, ifu_fb_consume2, fb_overflow_err
  );

  modport slave (
    input  ifc_fetch_req_f, ic_hit_f, ifc_fetch_addr_f, ic_data_f, ic_access_fault_f,
           exu_flush_final, dec_ib_ready,
    output ifu_i0_valid, ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_i0_icaf,
           ifu_fb_consume1, ifu_fb_consume2, fb_overflow_err
  );
endinterface

// File: rtl/css_mcu0_el2_ifu_fb_extract.sv
// Instruction extractor: turns the two head buffer entries into one decode instruction
// plus the halfword masks that accepting it would clear in each entry.
module css_mcu0_el2_ifu_fb_extract
  import css_mcu0_el2_pkg::*;
(
  input  el2_fb_entry_t e0,
  input  logic          e1_lo_valid,
  input  logic [15:0]   e1_lo_data,
  output logic          valid,
  output logic [31:0]   instr,
  output logic [31:1]   pc,
  output logic          pc4,
  output logic          icaf,
  output logic [1:0]    clr0,
  output logic [1:0]    clr1
);
  logic        at_hi;
  logic [15:0] cur_hw;

  // Decode the oldest valid halfword of E0; a 32-bit op starting in the upper half borrows E1's low half.
  always_comb begin
    valid  = 1'b0;
    instr  = '0;
    pc     = '0;
    pc4    = 1'b0;
    icaf   = 1'b0;
    clr0   = 2'b00;
    clr1   = 2'b00;
    at_hi  = ~e0.hw_valid[0];
    cur_hw = at_hi ? e0.data[31:16] : e0.data[15:0];
    if (e0.hw_valid != 2'b00) begin
      pc = {e0.pc, at_hi};
      if (e0.icaf) begin
        valid = 1'b1;
        icaf  = 1'b1;
        clr0  = e0.hw_valid;
      end else if (is_rvc(cur_hw)) begin
        valid = 1'b1;
        instr = {16'h0000, cur_hw};
        clr0  = at_hi ? 2'b10 : 2'b01;
      end else if (!at_hi) begin
        valid = 1'b1;
        instr = e0.data;
        pc4   = 1'b1;
        clr0  = 2'b11;
      end else if (e1_lo_valid) begin
        valid = 1'b1;
        instr = {e1_lo_data, cur_hw};
        pc4   = 1'b1;
        clr0  = 2'b10;
        clr1  = 2'b01;
      end
    end
  end
endmodule

// File: rtl/css_mcu0_el2_ifu_fb_ctl.sv
// Fetch buffer: 4-entry FIFO of fetch words feeding a 16/32-bit instruction extractor,
// reporting freed entries back to the fetch controller's occupancy model.
module css_mcu0_el2_ifu_fb_ctl
  import css_mcu0_el2_pkg::*;
#(
  parameter int FB_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  css_mcu0_el2_ifu_fb_ctl_if.slave fb
);

  if (FB_DEPTH != 4) begin : g_depth_check
    $error("css_mcu0_el2_ifu_fb_ctl: FB_DEPTH must be 4");
  end

  el2_fb_entry_t              entries_q [FB_DEPTH];
  el2_fb_entry_t              entries_d [FB_DEPTH];
  logic [FB_DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FB_DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FB_DEPTH_LOG2-1:0]   rd_ptr_p1;
  logic [FB_DEPTH_LOG2:0]     count_q, count_d;
  logic                       overflow_q, overflow_d;

  el2_fb_entry_t              e0;
  el2_fb_entry_t              wr_entry;
  logic [1:0]                 e1_hw_valid;
  logic [15:0]                e1_lo_data;
  logic                       ext_valid, ext_pc4, ext_icaf;
  logic [31:0]                ext_instr;
  logic [31:1]                ext_pc;
  logic [1:0]                 clr0, clr1;
  logic                       i0_valid, accept, free0, free1;
  logic                       wr_en, full, drop, do_wr;
  logic [1:0]                 n_free;

  assign rd_ptr_p1   = rd_ptr_q + FB_DEPTH_LOG2'(1);
  assign e0          = entries_q[rd_ptr_q];
  assign e1_hw_valid = entries_q[rd_ptr_p1].hw_valid;
  assign e1_lo_data  = entries_q[rd_ptr_p1].data[15:0];

  css_mcu0_el2_ifu_fb_extract u_extract (
    .e0          (e0),
    .e1_lo_valid (e1_hw_valid[0]),
    .e1_lo_data  (e1_lo_data),
    .valid       (ext_valid),
    .instr       (ext_instr),
    .pc          (ext_pc),
    .pc4         (ext_pc4),
    .icaf        (ext_icaf),
    .clr0        (clr0),
    .clr1        (clr1)
  );

  // Handshake and occupancy bookkeeping; an entry is freed once its last valid halfword is consumed.
  always_comb begin
    i0_valid = ext_valid & ~fb.exu_flush_final & ~rst;
    accept   = i0_valid & fb.dec_ib_ready;
    free0    = accept & (clr0 != 2'b00) & ((e0.hw_valid & ~clr0) == 2'b00);
    free1    = accept & (clr1 != 2'b00) & ((e1_hw_valid & ~clr1) == 2'b00);
    n_free   = {1'b0, free0} + {1'b0, free1};
    wr_en    = fb.ifc_fetch_req_f & fb.ic_hit_f & ~fb.exu_flush_final;
    full     = (count_q == (FB_DEPTH_LOG2 + 1)'(FB_DEPTH));
    drop     = wr_en & full & ~(free0 | free1);
    do_wr    = wr_en & ~drop;
  end

  // Package the incoming fetch word as an entry; an odd-halfword address carries only the upper half.
  always_comb begin
    wr_entry          = '0;
    wr_entry.hw_valid = fb.ifc_fetch_addr_f[1] ? 2'b10 : 2'b11;
    wr_entry.data     = fb.ic_data_f;
    wr_entry.pc       = fb.ifc_fetch_addr_f[31:2];
    wr_entry.icaf     = fb.ic_access_fault_f;
  end

  // Next FIFO state: flush empties everything, otherwise consume from the head then append the write.
  always_comb begin
    entries_d  = entries_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (fb.exu_flush_final) begin
      for (int i = 0; i < FB_DEPTH; i++) begin
        entries_d[i].hw_valid = 2'b00;
      end
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        entries_d[rd_ptr_q].hw_valid  = e0.hw_valid & ~clr0;
        entries_d[rd_ptr_p1].hw_valid = e1_hw_valid & ~clr1;
      end
      if (do_wr) begin
        entries_d[wr_ptr_q] = wr_entry;
        wr_ptr_d            = wr_ptr_q + FB_DEPTH_LOG2'(1);
      end
      rd_ptr_d = rd_ptr_q + FB_DEPTH_LOG2'(n_free);
      count_d  = count_q - (FB_DEPTH_LOG2 + 1)'(n_free) + (FB_DEPTH_LOG2 + 1)'(do_wr);
    end
  end

  // State registers with synchronous reset back to an empty buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      entries_q  <= entries_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign fb.ifu_i0_valid    = i0_valid;
  assign fb.ifu_i0_instr    = i0_valid ? ext_instr : '0;
  assign fb.ifu_i0_pc       = i0_valid ? ext_pc : '0;
  assign fb.ifu_i0_pc4      = i0_valid & ext_pc4;
  assign fb.ifu_i0_icaf     = i0_valid & ext_icaf;
  assign fb.ifu_fb_consume1 = free0 ^ free1;
  assign fb.ifu_fb_consume2 = free0 & free1;
  assign fb.fb_overflow_err = overflow_q;

endmodule
